// File: rtl/parking_if.sv
// Parking controller bus: request side (entry/exit pulses, exit space number)
// and status side (occupancy, counts, pulses, gate drive).
//   master : requester, drives entry_req / exit_req / exit_space
//   slave  : controller, drives all status and pulse outputs
interface parking_if #(
    parameter int unsigned SPACES = 8
);
    logic                            entry_req;
    logic                            exit_req;
    logic [$clog2(SPACES)-1:0]       exit_space;
    logic [SPACES-1:0]               occupancy;
    logic [$clog2(SPACES+1)-1:0]     free_count;
    logic                            full;
    logic [$clog2(SPACES)-1:0]       park_number;
    logic                            ticket_valid;
    logic                            exit_ack;
    logic                            reject;
    logic                            exit_err;
    logic                            gate_open;
    logic                            busy;

    modport master (
        output entry_req, exit_req, exit_space,
        input  occupancy, free_count, full, park_number, ticket_valid,
        input  exit_ack, reject, exit_err, gate_open, busy
    );

    modport slave (
        input  entry_req, exit_req, exit_space,
        output occupancy, free_count, full, park_number, ticket_valid,
        output exit_ack, reject, exit_err, gate_open, busy
    );
endinterface

// File: rtl/parking_controller.sv
// Parking lot entry/exit sequencer. Owns the occupancy vector and serves one
// car at a time: entries get the lowest free space and a ticket, exits free
// the named space; either opens the gate for GATE_CYCLES cycles.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : parking_if.slave (requests in, occupancy/status/pulses/gate out)
// SPACES must be a power of two >= 2 so every exit_space value names a space.
module parking_controller #(
    parameter int unsigned SPACES      = 8,
    parameter int unsigned GATE_CYCLES = 4
) (
    input  logic      clk,
    input  logic      rst,
    parking_if.slave  bus
);
    localparam int unsigned SpaceW = $clog2(SPACES);
    localparam int unsigned CountW = $clog2(SPACES + 1);
    localparam int unsigned CntW   = $clog2(GATE_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StGateIn, StGateOut} state_e;

    state_e              state_q, state_d;
    logic [SPACES-1:0]   occ_q, occ_d;
    logic [CountW-1:0]   free_q, free_d;
    logic [SpaceW-1:0]   park_q, park_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                ticket_q, ticket_d;
    logic                ack_q, ack_d;
    logic                reject_q, reject_d;
    logic                err_q, err_d;

    logic [SpaceW-1:0]   free_idx;
    logic                free_found;

    // Lowest free space: scan downward so the last hit is the lowest index.
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = int'(SPACES) - 1; i >= 0; i--) begin
            if (!occ_q[i]) begin
                free_idx   = SpaceW'(i);
                free_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        occ_d    = occ_q;
        free_d   = free_q;
        park_d   = park_q;
        cnt_d    = cnt_q;
        ticket_d = 1'b0;
        ack_d    = 1'b0;
        reject_d = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Exit has priority; a simultaneous entry is dropped silently.
                if (bus.exit_req) begin
                    if (occ_q[bus.exit_space]) begin
                        occ_d[bus.exit_space] = 1'b0;
                        free_d  = free_q + CountW'(1);
                        ack_d   = 1'b1;
                        cnt_d   = CntW'(GATE_CYCLES);
                        state_d = StGateOut;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.entry_req) begin
                    if (free_found) begin
                        occ_d[free_idx] = 1'b1;
                        free_d   = free_q - CountW'(1);
                        park_d   = free_idx;
                        ticket_d = 1'b1;
                        cnt_d    = CntW'(GATE_CYCLES);
                        state_d  = StGateIn;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            StGateIn, StGateOut: begin
                if (cnt_q == CntW'(1)) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            occ_q    <= '0;
            free_q   <= CountW'(SPACES);
            park_q   <= '0;
            cnt_q    <= '0;
            ticket_q <= 1'b0;
            ack_q    <= 1'b0;
            reject_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            occ_q    <= occ_d;
            free_q   <= free_d;
            park_q   <= park_d;
            cnt_q    <= cnt_d;
            ticket_q <= ticket_d;
            ack_q    <= ack_d;
            reject_q <= reject_d;
            err_q    <= err_d;
        end
    end

    assign bus.occupancy    = occ_q;
    assign bus.free_count   = free_q;
    assign bus.full         = &occ_q;
    assign bus.park_number  = park_q;
    assign bus.ticket_valid = ticket_q;
    assign bus.exit_ack     = ack_q;
    assign bus.reject       = reject_q;
    assign bus.exit_err     = err_q;
    // The gate is open for exactly the cycles spent in a gate state.
    assign bus.gate_open    = (state_q != StIdle);
    assign bus.busy         = (state_q != StIdle);
endmodule

// File: tb/tb_parking_controller.sv
// Bench for parking_controller: directed scenarios plus random traffic, all
// checked every cycle against a lot-level reference model.
module tb_parking_controller;
    localparam int unsigned SPACES      = 8;
    localparam int unsigned GATE_CYCLES = 4;
    localparam int unsigned SW          = $clog2(SPACES);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    parking_if #(.SPACES(SPACES)) bus ();

    parking_controller #(
        .SPACES      (SPACES),
        .GATE_CYCLES (GATE_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: lot as an array of spaces, gate as cycles remaining.
    bit m_occ[SPACES];
    int m_park;
    int m_gate;
    bit m_ticket, m_ack, m_reject, m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit e, input bit x, input int s, input bit r);
        int lowest;
        m_ticket = 0;
        m_ack    = 0;
        m_reject = 0;
        m_err    = 0;
        if (r) begin
            foreach (m_occ[i]) m_occ[i] = 0;
            m_park = 0;
            m_gate = 0;
        end else if (m_gate > 0) begin
            m_gate--;
        end else if (x) begin
            if (m_occ[s]) begin
                m_occ[s] = 0;
                m_ack    = 1;
                m_gate   = GATE_CYCLES;
            end else begin
                m_err = 1;
            end
        end else if (e) begin
            lowest = -1;
            for (int i = 0; i < int'(SPACES); i++) begin
                if (!m_occ[i]) begin
                    lowest = i;
                    break;
                end
            end
            if (lowest < 0) begin
                m_reject = 1;
            end else begin
                m_occ[lowest] = 1;
                m_park   = lowest;
                m_ticket = 1;
                m_gate   = GATE_CYCLES;
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] vec;
        int          taken;
        vec   = '0;
        taken = 0;
        for (int i = 0; i < int'(SPACES); i++) begin
            vec[i] = m_occ[i];
            taken += int'(m_occ[i]);
        end
        check_eq("occupancy",    32'(bus.occupancy),    vec);
        check_eq("free_count",   32'(bus.free_count),   32'(int'(SPACES) - taken));
        check_eq("full",         32'(bus.full),         32'(taken == int'(SPACES)));
        check_eq("park_number",  32'(bus.park_number),  32'(m_park));
        check_eq("ticket_valid", 32'(bus.ticket_valid), 32'(m_ticket));
        check_eq("exit_ack",     32'(bus.exit_ack),     32'(m_ack));
        check_eq("reject",       32'(bus.reject),       32'(m_reject));
        check_eq("exit_err",     32'(bus.exit_err),     32'(m_err));
        check_eq("gate_open",    32'(bus.gate_open),    32'(m_gate > 0));
        check_eq("busy",         32'(bus.busy),         32'(m_gate > 0));
    endtask

    // Present one cycle of inputs, let the edge take them, compare mid-cycle.
    task automatic cycle(input bit e, input bit x, input int s, input bit r);
        bus.entry_req  = e;
        bus.exit_req   = x;
        bus.exit_space = SW'(s);
        rst            = r;
        @(posedge clk);
        model_step(e, x, s, r);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0);
    endtask

    initial begin
        bus.entry_req  = 1'b0;
        bus.exit_req   = 1'b0;
        bus.exit_space = '0;

        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check_eq("reset_free", 32'(bus.free_count), 32'd8);

        // First entry takes space 0.
        cycle(1, 0, 0, 0);
        check_eq("first_park", 32'(bus.park_number), 32'd0);
        check_eq("first_occ",  32'(bus.occupancy),   32'h01);
        idle(GATE_CYCLES);

        // Fill the lot, then one more entry is refused.
        for (int k = 1; k < int'(SPACES); k++) begin
            cycle(1, 0, 0, 0);
            check_eq("fill_park", 32'(bus.park_number), 32'(k));
            idle(GATE_CYCLES);
        end
        check_eq("full_flag", 32'(bus.full), 32'd1);
        cycle(1, 0, 0, 0);
        check_eq("reject_full", 32'(bus.reject), 32'd1);
        idle(1);

        // Exit from space 3, then the next entry reuses it.
        cycle(0, 1, 3, 0);
        check_eq("exit3_occ", 32'(bus.occupancy), 32'hF7);
        idle(GATE_CYCLES);
        cycle(1, 0, 0, 0);
        check_eq("reuse_park", 32'(bus.park_number), 32'd3);
        idle(GATE_CYCLES);

        // Simultaneous entry and exit on a full lot: exit wins, no reject.
        cycle(1, 1, 0, 0);
        check_eq("simul_occ",    32'(bus.occupancy), 32'hFE);
        check_eq("simul_reject", 32'(bus.reject),    32'd0);
        idle(GATE_CYCLES);

        // Exit of an empty space is an error with no gate.
        cycle(0, 0, 0, 1);
        cycle(1, 0, 0, 0);
        idle(GATE_CYCLES);
        cycle(0, 1, 5, 0);
        check_eq("err_pulse", 32'(bus.exit_err),  32'd1);
        check_eq("err_gate",  32'(bus.gate_open), 32'd0);
        idle(1);

        // Entry while gate is open is dropped; reset mid-gate aborts.
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check_eq("busy_drop_occ", 32'(bus.occupancy), 32'h03);
        cycle(0, 0, 0, 1);
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        idle(2);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom % 3) == 0, ($urandom % 4) == 0,
                  int'($urandom_range(SPACES - 1)), ($urandom % 200) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
